// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel divider, h/v counters and a
// registered decode stage producing syncs, coordinates and event strobes.
module vga_timing_gen #(
  parameter int       H_ACTIVE = 640,
  parameter int       H_FP     = 16,
  parameter int       H_SYNC   = 96,
  parameter int       H_BP     = 48,
  parameter int       V_ACTIVE = 480,
  parameter int       V_FP     = 11,
  parameter int       V_SYNC   = 2,
  parameter int       V_BP     = 31,
  parameter logic     HS_POL   = 1'b0,
  parameter logic     VS_POL   = 1'b0,
  parameter int       PIX_DIV  = 1,
  parameter int       CNT_W    = 10,
  parameter int       FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_ce,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_ON  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_ON  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   v_q, v_d;
  logic               wrapped_q, wrapped_d;
  logic               tick, h_wrap, v_wrap;

  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic               video_on_q, video_on_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               pix_ce_q, pix_ce_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               vblank_start_q, vblank_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               first_clk, active;

  // Raster counters; wrapped_q marks that (0,0) was reached by a frame wrap
  // rather than by reset or enable, which gates the frame counter.
  always_comb begin
    tick      = (div_q == DIV_LAST);
    h_wrap    = tick && (h_q == H_LAST);
    v_wrap    = h_wrap && (v_q == V_LAST);
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    h_d       = h_q;
    v_d       = v_q;
    wrapped_d = wrapped_q | v_wrap;
    if (tick) h_d = h_wrap ? '0 : h_q + CNT_W'(1);
    if (h_wrap) v_d = v_wrap ? '0 : v_q + CNT_W'(1);
    if (!en) begin
      div_d     = '0;
      h_d       = '0;
      v_d       = '0;
      wrapped_d = 1'b0;
    end
  end

  // Decode stage: everything below is registered, one clk behind the counters.
  always_comb begin
    first_clk      = en && (div_q == '0);
    active         = (h_q < H_ACT) && (v_q < V_ACT);
    video_on_d     = en && active;
    x_d            = video_on_d ? h_q : '0;
    y_d            = video_on_d ? v_q : '0;
    hsync_d        = (en && in_window(h_q, H_SYNC_ON, H_SYNC_OFF)) ? HS_POL : ~HS_POL;
    vsync_d        = (en && in_window(v_q, V_SYNC_ON, V_SYNC_OFF)) ? VS_POL : ~VS_POL;
    pix_ce_d       = first_clk;
    line_start_d   = first_clk && (h_q == '0);
    frame_start_d  = line_start_d && (v_q == '0);
    vblank_start_d = line_start_d && (v_q == V_ACT);
    frame_cnt_d    = (frame_start_d && wrapped_q) ? frame_cnt_q + FRAME_W'(1) : frame_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q          <= '0;
      h_q            <= '0;
      v_q            <= '0;
      wrapped_q      <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      video_on_q     <= 1'b0;
      hsync_q        <= ~HS_POL;
      vsync_q        <= ~VS_POL;
      pix_ce_q       <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      div_q          <= div_d;
      h_q            <= h_d;
      v_q            <= v_d;
      wrapped_q      <= wrapped_d;
      x_q            <= x_d;
      y_q            <= y_d;
      video_on_q     <= video_on_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      pix_ce_q       <= pix_ce_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign video_on     = video_on_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign pix_ce       = pix_ce_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, PIX_DIV=4 and a small
// positive-polarity raster with FRAME_W=2, driven from a shared clock.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_def = 1'b1;
  logic en_sm  = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] d_x, d_y, q_x, q_y;
  logic       d_von, d_hs, d_vs, d_pce, d_ls, d_fs, d_vb;
  logic       q_von, q_hs, q_vs, q_pce, q_ls, q_fs, q_vb;
  logic [7:0] d_fc, q_fc;
  logic [3:0] s_x, s_y;
  logic       s_von, s_hs, s_vs, s_pce, s_ls, s_fs, s_vb;
  logic [1:0] s_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .en(en_def), .x(d_x), .y(d_y), .video_on(d_von),
    .hsync(d_hs), .vsync(d_vs), .pix_ce(d_pce), .line_start(d_ls),
    .frame_start(d_fs), .vblank_start(d_vb), .frame_cnt(d_fc));

  vga_timing_gen #(.PIX_DIV(4)) u_d4 (
    .clk(clk), .rst(rst), .en(en_def), .x(q_x), .y(q_y), .video_on(q_von),
    .hsync(q_hs), .vsync(q_vs), .pix_ce(q_pce), .line_start(q_ls),
    .frame_start(q_fs), .vblank_start(q_vb), .frame_cnt(q_fc));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .FRAME_W(2)) u_sm (
    .clk(clk), .rst(rst), .en(en_sm), .x(s_x), .y(s_y), .video_on(s_von),
    .hsync(s_hs), .vsync(s_vs), .pix_ce(s_pce), .line_start(s_ls),
    .frame_start(s_fs), .vblank_start(s_vb), .frame_cnt(s_fc));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         adv;
    logic [3:0] x, y;
    logic       von, hs, vs, pce, ls, fs, vb;
    logic [1:0] fc;
  } sm_vec_t;

  function automatic sm_vec_t mk(input int adv, input int x, input int y, input int von,
                                 input int hs, input int vs, input int pce, input int ls,
                                 input int fs, input int vb, input int fc);
    sm_vec_t r;
    r.adv = adv;  r.x = 4'(x);    r.y = 4'(y);    r.von = 1'(von);
    r.hs = 1'(hs); r.vs = 1'(vs); r.pce = 1'(pce); r.ls = 1'(ls);
    r.fs = 1'(fs); r.vb = 1'(vb); r.fc = 2'(fc);
    return r;
  endfunction

  function automatic logic [16:0] sm_pack(input sm_vec_t r);
    return {r.x, r.y, r.von, r.hs, r.vs, r.pce, r.ls, r.fs, r.vb, r.fc};
  endfunction

  initial begin
    sm_vec_t tbl[14];
    sm_vec_t row;
    int von_cnt, hs_low, hs_first, bad4, ls4, idle_bad;
    logic found;

    // small raster, H_TOTAL=14, V_TOTAL=7; adv = clks since the previous row
    tbl[0]  = mk( 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0);
    tbl[1]  = mk( 7, 7, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk( 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk( 2, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk( 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk( 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk( 2, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[7]  = mk( 3, 3, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(39, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    tbl[9]  = mk(14, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    tbl[10] = mk(10, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    tbl[11] = mk( 4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[12] = mk(13, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[13] = mk( 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1);

    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_def_hsync", d_hs, 1);
    chk("rst_def_vsync", d_vs, 1);
    chk("rst_def_von_fs", {d_von, d_fs, d_ls, d_pce, d_vb}, 0);
    chk("rst_def_xy_fc", {d_x, d_y, d_fc}, 0);
    chk("rst_sm_syncs", {s_hs, s_vs}, 0);

    // default and PIX_DIV=4 from reset release
    @(negedge clk);
    rst = 1'b0;
    von_cnt = 0; hs_low = 0; hs_first = -1; bad4 = 0; ls4 = 0;
    for (int c = 0; c < 3300; c++) begin
      step();
      if (c == 0) begin
        chk("def_first_xy", {d_x, d_y}, 0);
        chk("def_first_strobes", {d_von, d_fs, d_ls, d_pce, d_vb}, 5'b11110);
        chk("def_first_fc", d_fc, 0);
      end
      if (c < 800) begin
        if (d_von) von_cnt++;
        if (!d_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = c;
        end
      end
      if (c == 639) chk("def_x639", {d_x, d_von}, {10'd639, 1'b1});
      if (c == 640) chk("def_after_active", {d_x, d_von}, 0);
      if (c == 800) chk("def_line1", {d_ls, d_fs, d_x, d_y, d_von}, {2'b10, 10'd0, 10'd1, 1'b1});
      if (c < 3200) begin
        if (q_x != ((c / 4 < 640) ? 10'(c / 4) : 10'd0)) bad4++;
        if (q_pce != ((c % 4) == 0)) bad4++;
        if (q_ls) ls4++;
      end
      if (c == 2559) chk("d4_x639", {q_x, q_von}, {10'd639, 1'b1});
      if (c == 2560) chk("d4_after_active", {q_x, q_von}, 0);
      if (c == 3200) chk("d4_line1", {q_ls, q_y, q_x}, {1'b1, 10'd1, 10'd0});
    end
    chk("def_von_per_line", von_cnt, 640);
    chk("def_hsync_low_cnt", hs_low, 96);
    chk("def_hsync_first", hs_first, 656);
    chk("d4_hold_and_ce", bad4, 0);
    chk("d4_line_start_cnt", ls4, 1);
    chk("sm_idle_while_off", {s_von, s_hs, s_vs, s_pce, s_ls, s_fs}, 0);

    // small raster from en rising, table-driven over one frame
    en_sm = 1'b1;
    for (int i = 0; i < 14; i++) begin
      row = tbl[i];
      repeat (row.adv) step();
      chk($sformatf("sm_row%0d", i),
          {s_x, s_y, s_von, s_hs, s_vs, s_pce, s_ls, s_fs, s_vb, s_fc}, sm_pack(row));
    end

    // frame counter through wrap
    repeat (196) step();
    chk("sm_frame3", {s_fs, s_fc}, {1'b1, 2'd3});
    repeat (98) step();
    chk("sm_frame_wrap", {s_fs, s_fc}, {1'b1, 2'd0});

    // en dropped mid-frame at (5,2) for 10 clks
    repeat (33) step();
    chk("sm_pre_drop", {s_x, s_y, s_von}, {4'd5, 4'd2, 1'b1});
    en_sm = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({s_x, s_y, s_von, s_hs, s_vs, s_pce, s_ls, s_fs, s_vb} != 0) idle_bad++;
      if (s_fc != 2'd0) idle_bad++;
    end
    chk("sm_idle_gap", idle_bad, 0);
    en_sm = 1'b1;
    step();
    chk("sm_resume", {s_x, s_y, s_von, s_pce, s_ls, s_fs, s_fc}, {8'd0, 4'b1111, 2'd0});
    repeat (98) step();
    chk("sm_resume_next_frame", {s_fs, s_fc}, {1'b1, 2'd1});

    // asynchronous reset mid-line
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (d_x == 10'd500 && d_von) found = 1'b1;
    end
    chk("def_find_x500", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_def_outputs", {d_x, d_y, d_von, d_hs, d_vs, d_pce, d_ls, d_fs, d_vb},
        {20'd0, 1'b0, 1'b1, 1'b1, 4'b0000});
    chk("arst_sm_fc", {s_fc, s_hs, s_vs}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("arst_def_restart", {d_fs, d_ls, d_von, d_x, d_y, d_fc}, {3'b111, 28'd0});
    chk("arst_sm_restart", {s_fs, s_fc}, {1'b1, 2'd0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA display path, replacing the fixed 640x480 sync block. It produces registered hsync/vsync, active-area x/y coordinates, video_on, and per-pixel, per-line and per-frame strobes for the pixel pipeline and frame-buffer logic. All horizontal and vertical segment lengths, sync polarities, pixel clock division and counter widths are parameters. A run enable restarts the raster cleanly from the top-left pixel.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum of the four = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 11, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 31, vertical back porch (lines); V_TOTAL = 524
- HS_POL, 0, active level of hsync
- VS_POL, 0, active level of vsync
- PIX_DIV, 1, clk cycles per pixel (>=1)
- CNT_W, 10, width of x, y and internal counters; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8, width of frame_cnt
- Clock and reset: clk; reset rst, asynchronous, active-high.
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  run enable; low holds the raster at its start point
- x  out  CNT_W  horizontal pixel index in the active area, else 0
- y  out  CNT_W  line index in the active area, else 0
- video_on  out  1  high when the current pixel is in the active area
- hsync  out  1  horizontal sync, HS_POL active
- vsync  out  1  vertical sync, VS_POL active
- pix_ce  out  1  one-clk strobe on the first clk of each new pixel
- line_start  out  1  one-clk strobe on the first clk of pixel h=0
- frame_start  out  1  one-clk strobe on the first clk of pixel (0,0)
- vblank_start  out  1  one-clk strobe on the first clk of pixel (0,V_ACTIVE)
- frame_cnt  out  FRAME_W  completed-frame counter, wraps modulo 2^FRAME_W

## Operation
- Divider div 0..PIX_DIV-1 advances every clk while en=1. The internal tick fires when div==PIX_DIV-1.
- On each tick, h advances, wrapping at H_TOTAL-1 to 0. When h wraps, v advances, wrapping at V_TOTAL-1 to 0. When v wraps, frame_cnt increments.
- Decode, applied to the displayed (h,v):
  - active = h<H_ACTIVE && v<V_ACTIVE
  - hsync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vsync is active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
  - With defaults: hsync active for h 656..751, vsync active for v 491..492.
- x=h and y=v only when active; otherwise both are 0.
- All outputs are registered. They hold their values for all PIX_DIV clks of a pixel.
- The strobes pix_ce, line_start, frame_start and vblank_start assert only on the first clk of their pixel.
- en=0 synchronously clears div, h and v to 0 on the next clk. While en=0:
  - video_on=0, hsync and vsync are inactive, all strobes are 0, x=y=0.
  - frame_cnt holds its value.
- en rising: raster restarts at pixel (0,0). frame_start, line_start and pix_ce all strobe on the first displayed clk.
- Reset values: all counters 0, x=y=0, video_on=0, all strobes 0, frame_cnt=0, hsync=~HS_POL, vsync=~VS_POL.
- Reset mid-frame: outputs return to reset values immediately (asynchronously). Operation restarts as for en rising.

## Timing
- Pipeline: counter state is decoded and registered, so outputs lag the counters by exactly one clk.
- From the first rising clk edge after rst deasserts (en=1): the outputs show pixel (0,0) with video_on=1, frame_start=1, line_start=1, pix_ce=1.
- Each pixel is presented for exactly PIX_DIV clks.
- Line period = H_TOTAL*PIX_DIV clks. Frame period = H_TOTAL*V_TOTAL*PIX_DIV clks (419,200 with defaults).
- frame_cnt increments on the same clk that frame_start asserts, except for the first frame after reset or en rising.
- Simultaneous events: on pixel (0,0), line_start and frame_start assert together. vblank_start never coincides with frame_start (requires V_ACTIVE<V_TOTAL).
- en falling mid-pixel: outputs go inactive one clk later, with no partial strobes.

## Test plan
- Reset then en=1, defaults: first clk shows x=0, y=0, video_on=1, frame_start=1. Exactly 640 video_on clks per visible line. hsync low for clks 656..751 after each line_start.
- Full frame, defaults: frame_start period 419,200 clks. vsync low for lines 491..492 (1600 clks). vblank_start on line 480. frame_cnt 0->1 on the second frame_start.
- PIX_DIV=4: each x value is held 4 clks and pix_ce pulses every 4 clks. Line period is 3200 clks; x=639 is followed by video_on=0.
- HS_POL=1, VS_POL=1, small raster (H 8/2/2/2, V 4/1/1/1): hsync high only at h=10..11. vsync high only at v=5. Frame = 14*7 clks.
- en dropped at (300,200) for 10 clks, then raised: outputs idle (video_on=0, syncs inactive) during the gap. On resume, (0,0) frame_start. frame_cnt is unchanged by the gap.
- rst pulse mid-line at (500,100): outputs go to reset values asynchronously. After release, frame_start follows at the next clk and frame_cnt=0. Also run FRAME_W=2 for 5 frames and check frame_cnt wraps 3->0.
